// File: rtl/adder_pkg.sv
// adder_pkg: shared types, parameter check and saturation constants for pipelined_adder
package adder_pkg;
    localparam int MAX_WIDTH = 256;
    typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} op_e;
    function automatic bit params_ok(input int width, input int stages);
        return width >= 2 && stages >= 1 && width % stages == 0;
    endfunction
    function automatic logic [MAX_WIDTH-1:0] sat_max(input int width);
        logic [MAX_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < width - 1; i++) r[i] = 1'b1;
        return r;
    endfunction
    function automatic logic [MAX_WIDTH-1:0] sat_min(input int width);
        logic [MAX_WIDTH-1:0] r;
        r = '0;
        r[width-1] = 1'b1;
        return r;
    endfunction
endpackage

// File: rtl/pipelined_adder_if.sv
// pipelined_adder_if: operand/result valid-ready bundle for pipelined_adder
//   in_valid/in_ready/a/b/cin/op : operand beat (master -> slave)
//   out_valid/out_ready/sum/cout/overflow : result beat (slave -> master)
interface pipelined_adder_if #(parameter int WIDTH = 16);
    import adder_pkg::*;
    logic in_valid;
    logic in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic cin;
    op_e op;
    logic out_valid;
    logic out_ready;
    logic [WIDTH-1:0] sum;
    logic cout;
    logic overflow;
    modport slave(input in_valid, a, b, cin, op, out_ready, output in_ready, out_valid, sum, cout, overflow);
    modport master(output in_valid, a, b, cin, op, out_ready, input in_ready, out_valid, sum, cout, overflow);
endinterface

// File: rtl/adder_stage.sv
// adder_stage: one C-bit carry segment, registered chunk sum, carry-out and valid
//   clk, rst_n (async, active-low), en (global advance)
//   valid_prev/carry_prev/a/b : inputs aligned to this stage
//   valid/carry/s             : registered results
module adder_stage #(parameter int C = 4) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         valid_prev,
    input  logic         carry_prev,
    input  logic [C-1:0] a,
    input  logic [C-1:0] b,
    output logic         valid,
    output logic         carry,
    output logic [C-1:0] s
);
    logic [C:0] total;
    assign total = {1'b0, a} + {1'b0, b} + {{C{1'b0}}, carry_prev};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            carry <= 1'b0;
            s     <= '0;
        end else if (en) begin
            valid <= valid_prev;
            carry <= total[C];
            s     <= total[C-1:0];
        end
    end
endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit add/sub split into STAGES registered carry segments
//   clk, rst_n (async, active-low), bus : pipelined_adder_if.slave
//   Macro PIPELINED_ADDER_SAT_EN: saturate sum on signed overflow (default wraps)
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input logic              clk,
    input logic              rst_n,
    pipelined_adder_if.slave bus
);
    localparam int C = WIDTH / STAGES;
    if (!params_ok(WIDTH, STAGES)) begin : g_bad
        $error("pipelined_adder: illegal WIDTH=%0d STAGES=%0d", WIDTH, STAGES);
    end
    logic en, cin_eff, msb_x, ovf;
    logic [WIDTH-1:0] b_eff, raw;
    logic [STAGES-1:0] valid, carry;
    logic [C-1:0] chunk [STAGES];
    assign en = !valid[STAGES-1] || bus.out_ready;
    assign bus.in_ready = rst_n && en;
    assign b_eff = bus.op == OP_SUB ? ~bus.b : bus.b;
    assign cin_eff = bus.op == OP_SUB ? !bus.cin : bus.cin;
    for (genvar k = 0; k < STAGES; k++) begin : g_st
        // ka/kb: operand chunks k and above, delayed k cycles; acc: result bits below and including chunk k
        logic [WIDTH-k*C-1:0] ka, kb;
        logic [(k+1)*C-1:0] acc;
        logic v_prev, c_prev;
        if (k == 0) begin : g_first
            assign ka = bus.a;
            assign kb = b_eff;
            assign v_prev = bus.in_valid;
            assign c_prev = cin_eff;
            assign acc = chunk[0];
        end else begin : g_rest
            logic [k*C-1:0] lo;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ka <= '0;
                    kb <= '0;
                    lo <= '0;
                end else if (en) begin
                    ka <= g_st[k-1].ka[WIDTH-(k-1)*C-1:C];
                    kb <= g_st[k-1].kb[WIDTH-(k-1)*C-1:C];
                    lo <= g_st[k-1].acc;
                end
            end
            assign v_prev = valid[k-1];
            assign c_prev = carry[k-1];
            assign acc = {chunk[k], lo};
        end
        adder_stage #(.C(C)) u_stage (
            .clk(clk), .rst_n(rst_n), .en(en),
            .valid_prev(v_prev), .carry_prev(c_prev),
            .a(ka[C-1:0]), .b(kb[C-1:0]),
            .valid(valid[k]), .carry(carry[k]), .s(chunk[k])
        );
    end
    // Carry into the MSB is a^b^sum at that bit, so keeping a^b of the top bit is enough for overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) msb_x <= 1'b0;
        else if (en) msb_x <= g_st[STAGES-1].ka[C-1] ^ g_st[STAGES-1].kb[C-1];
    end
    assign raw = g_st[STAGES-1].acc;
    assign ovf = raw[WIDTH-1] ^ msb_x ^ carry[STAGES-1];
    assign bus.out_valid = valid[STAGES-1];
    assign bus.cout = carry[STAGES-1];
    assign bus.overflow = ovf;
`ifdef PIPELINED_ADDER_SAT_EN
    // On overflow the raw sign is flipped, so a negative raw result means positive operands
    assign bus.sum = ovf ? (raw[WIDTH-1] ? WIDTH'(sat_max(WIDTH)) : WIDTH'(sat_min(WIDTH))) : raw;
`else
    assign bus.sum = raw;
`endif
endmodule
